cpu_run_monitor: RTL and testbench



---
 rtl/cpu_run_monitor.sv | 158 +++++++++++++++
 tb/tb_cpu_run_monitor.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor
//   Watches the fetch stream of the multi-cycle CPU. It raises a sticky halt
//   flag when the program ends, and records the cause. A run ends on an exit
//   syscall, on a jump-to-self loop, or when the cycle budget runs out. The
//   block also counts cycles and fetches and keeps a ring of recent fetch PCs.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   clear        synchronous restart; beats every other input
//   ir_valid     one-cycle strobe: a new instruction was latched into IR
//   pc, ir, v0   fetch PC, instruction word and $2, sampled with ir_valid
//   halted       sticky run-finished flag
//   exit_cause   0 none, 1 exit syscall, 2 self-loop, 3 timeout
//   cycle_count  clock edges spent in RUN
//   instr_count  accepted ir_valid strobes
//   trace_age    ring read index; 0 selects the newest entry
//   trace_pc     PC at trace_age (combinational)
//   trace_valid  trace_age < trace_fill
//   trace_fill   number of valid ring entries, saturating at 2^TRACE_AW
module cpu_run_monitor #(
  parameter int TRACE_AW   = 4,
  parameter int LOOP_LIMIT = 4,
  parameter int MAX_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                ir_valid,
  input  logic [31:0]         pc,
  input  logic [31:0]         ir,
  input  logic [31:0]         v0,
  output logic                halted,
  output logic [1:0]          exit_cause,
  output logic [31:0]         cycle_count,
  output logic [31:0]         instr_count,
  input  logic [TRACE_AW-1:0] trace_age,
  output logic [31:0]         trace_pc,
  output logic                trace_valid,
  output logic [TRACE_AW:0]   trace_fill
);

  localparam int              DEPTH      = 1 << TRACE_AW;
  localparam logic [TRACE_AW:0] FILL_MAX = (TRACE_AW+1)'(DEPTH);
  localparam logic [7:0]      LOOP_LAST  = 8'(LOOP_LIMIT - 1);
  localparam logic [31:0]     CYC_LAST   = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]     SYSCALL_IR = 32'h0000_000C;
  localparam logic [31:0]     EXIT_CODE  = 32'd10;

  typedef enum logic {RUN, HALTED} state_t;

  state_t              state_q, state_d;
  logic [1:0]          cause_q, cause_d;
  logic [31:0]         cyc_q, cyc_d;
  logic [31:0]         instr_q, instr_d;
  logic [31:0]         last_pc_q, last_pc_d;
  logic [7:0]          loop_cnt_q, loop_cnt_d;
  logic [TRACE_AW-1:0] wptr_q, wptr_d;
  logic [TRACE_AW:0]   fill_q, fill_d;
  logic                ring_we;
  logic                repeat_fetch;
  logic [TRACE_AW-1:0] rd_idx;

  // Ring contents are deliberately not reset: trace_fill tells readers which
  // entries mean anything.
  logic [31:0] ring [DEPTH];

  // A fetch is a repeat only when there is a previous fetch to compare with.
  // last_pc resets to 0, so a first fetch at PC 0 must not count.
  assign repeat_fetch = (pc == last_pc_q) && (fill_q != '0);

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    cyc_d      = cyc_q;
    instr_d    = instr_q;
    last_pc_d  = last_pc_q;
    loop_cnt_d = loop_cnt_q;
    wptr_d     = wptr_q;
    fill_d     = fill_q;
    ring_we    = 1'b0;

    if (clear) begin
      state_d    = RUN;
      cause_d    = 2'd0;
      cyc_d      = '0;
      instr_d    = '0;
      last_pc_d  = '0;
      loop_cnt_d = '0;
      wptr_d     = '0;
      fill_d     = '0;
    end else if (state_q == RUN) begin
      // The edge that enters HALTED still does all of this edge's updates.
      cyc_d = cyc_q + 32'd1;
      if (ir_valid) begin
        ring_we    = 1'b1;
        instr_d    = instr_q + 32'd1;
        wptr_d     = wptr_q + TRACE_AW'(1);
        fill_d     = (fill_q == FILL_MAX) ? fill_q : fill_q + (TRACE_AW+1)'(1);
        loop_cnt_d = repeat_fetch ? loop_cnt_q + 8'd1 : 8'd0;
        last_pc_d  = pc;
      end

      // When several halt conditions hold, the earlier test wins.
      if (ir_valid && ir == SYSCALL_IR && v0 == EXIT_CODE) begin
        state_d = HALTED;
        cause_d = 2'd1;
      end else if (ir_valid && repeat_fetch && loop_cnt_q == LOOP_LAST) begin
        state_d = HALTED;
        cause_d = 2'd2;
      end else if (cyc_q == CYC_LAST) begin
        state_d = HALTED;
        cause_d = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      cause_q    <= 2'd0;
      cyc_q      <= '0;
      instr_q    <= '0;
      last_pc_q  <= '0;
      loop_cnt_q <= '0;
      wptr_q     <= '0;
      fill_q     <= '0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      cyc_q      <= cyc_d;
      instr_q    <= instr_d;
      last_pc_q  <= last_pc_d;
      loop_cnt_q <= loop_cnt_d;
      wptr_q     <= wptr_d;
      fill_q     <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ring_we) begin
      ring[wptr_q] <= pc;
    end
  end

  // The newest entry sits one slot behind the write pointer. The index
  // wraps naturally in TRACE_AW bits.
  assign rd_idx      = wptr_q - TRACE_AW'(1) - trace_age;
  assign trace_pc    = ring[rd_idx];
  assign trace_valid = {1'b0, trace_age} < fill_q;

  assign halted      = (state_q == HALTED);
  assign exit_cause  = cause_q;
  assign cycle_count = cyc_q;
  assign instr_count = instr_q;
  assign trace_fill  = fill_q;

endmodule

// File: tb/tb_cpu_run_monitor.sv
module tb_cpu_run_monitor;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int LL    = 4;
  localparam int MC    = 50;

  logic          clk;
  logic          reset;
  logic          clear;
  logic          ir_valid;
  logic [31:0]   pc;
  logic [31:0]   ir;
  logic [31:0]   v0;
  logic          halted;
  logic [1:0]    exit_cause;
  logic [31:0]   cycle_count;
  logic [31:0]   instr_count;
  logic [AW-1:0] trace_age;
  logic [31:0]   trace_pc;
  logic          trace_valid;
  logic [AW:0]   trace_fill;

  cpu_run_monitor #(.TRACE_AW(AW), .LOOP_LIMIT(LL), .MAX_CYCLES(MC)) dut (
    .clk(clk), .reset(reset), .clear(clear), .ir_valid(ir_valid),
    .pc(pc), .ir(ir), .v0(v0), .halted(halted), .exit_cause(exit_cause),
    .cycle_count(cycle_count), .instr_count(instr_count),
    .trace_age(trace_age), .trace_pc(trace_pc), .trace_valid(trace_valid),
    .trace_fill(trace_fill)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        h;
    bit [1:0]  c;
    bit [31:0] cyc;
    bit [31:0] ins;
    int        fill;
    bit        tv;
    bit [31:0] tpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: a run is a list of fetched PCs plus a few tallies.
  bit        m_h;
  bit [1:0]  m_c;
  bit [31:0] m_cyc;
  bit [31:0] m_ins;
  bit [31:0] hist[$];   // last DEPTH fetched PCs, oldest first
  int        streak;    // fetches in a row at the same PC

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_c = 0; m_cyc = 0; m_ins = 0; streak = 0;
    hist.delete();
  endtask

  task automatic model_edge(input bit clr, input bit v, input bit [31:0] p,
                            input bit [31:0] i, input bit [31:0] vv);
    bit [1:0] cause;
    if (clr) begin
      model_reset();
      return;
    end
    if (m_h) return;
    m_cyc++;
    cause = 0;
    if (v) begin
      m_ins++;
      streak = (hist.size() > 0 && p == hist[hist.size()-1]) ? streak + 1 : 1;
      hist.push_back(p);
      if (hist.size() > DEPTH) void'(hist.pop_front());
      if (i == 32'hC && vv == 10) cause = 1;
      else if (streak == LL + 1)  cause = 2;
    end
    if (cause == 0 && m_cyc == MC) cause = 3;
    if (cause != 0) begin
      m_h = 1;
      m_c = cause;
    end
  endtask

  // Drive one cycle of input. The model advances on the same edge, and the
  // expected post-edge state goes to the scoreboard. age < 0 picks a random age.
  task automatic step(input bit clr, input bit v, input bit [31:0] p,
                      input bit [31:0] i, input bit [31:0] vv, input int age);
    exp_t e;
    int   a;
    clear = clr; ir_valid = v; pc = p; ir = i; v0 = vv;
    @(posedge clk);
    #1;
    model_edge(clr, v, p, i, vv);
    a = (age < 0) ? int'($urandom_range(DEPTH-1)) : age;
    trace_age = a[AW-1:0];
    e.h    = m_h;
    e.c    = m_c;
    e.cyc  = m_cyc;
    e.ins  = m_ins;
    e.fill = hist.size();
    e.tv   = a < hist.size();
    e.tpc  = e.tv ? hist[hist.size()-1-a] : 32'h0;
    exp_q.push_back(e);
    clear = 0; ir_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 32'h0, 32'h0, 32'h0, -1);
  endtask

  task automatic fetch(input bit [31:0] p, input bit [31:0] i, input bit [31:0] vv, input int age);
    step(0, 1, p, i, vv, age);
  endtask

  task automatic async_reset_check();
    @(negedge clk);
    #1;
    reset = 0;
    #1;
    chk("async_halted", 32'(halted), 32'h0);
    chk("async_cause", 32'(exit_cause), 32'h0);
    chk("async_cycles", cycle_count, 32'h0);
    chk("async_instr", instr_count, 32'h0);
    chk("async_fill", 32'(trace_fill), 32'h0);
    chk("async_tvalid", 32'(trace_valid), 32'h0);
    model_reset();
    @(negedge clk);
    #1;
    reset = 1;
  endtask

  // Monitor: every clock the DUT presents a new registered state. That state
  // is compared with the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("halted", 32'(halted), 32'(mon_e.h));
      chk("exit_cause", 32'(exit_cause), 32'(mon_e.c));
      chk("cycle_count", cycle_count, mon_e.cyc);
      chk("instr_count", instr_count, mon_e.ins);
      chk("trace_fill", 32'(trace_fill), 32'(mon_e.fill));
      chk("trace_valid", 32'(trace_valid), 32'(mon_e.tv));
      if (mon_e.tv) chk("trace_pc", trace_pc, mon_e.tpc);
    end
  end

  localparam bit [31:0] ADD = 32'h0000_0020;
  localparam bit [31:0] SYS = 32'h0000_000C;

  initial begin
    bit [31:0] rpc;
    bit [31:0] rir;
    bit [31:0] rv0;
    int        n;
    reset = 0; clear = 0; ir_valid = 0; pc = 0; ir = 0; v0 = 0; trace_age = 0;
    model_reset();
    #12;
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_cycles", cycle_count, 32'h0);
    chk("rst_fill", 32'(trace_fill), 32'h0);
    reset = 1;

    // Three plain fetches, then read ages 0, 2 and 3.
    fetch(32'h0, ADD, 0, -1);
    fetch(32'h4, ADD, 0, -1);
    fetch(32'h8, ADD, 0, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 0, 3);

    // A syscall with v0=4 is ordinary; with v0=10 it halts. Counters then freeze.
    fetch(32'h3C, SYS, 4, -1);
    fetch(32'h40, SYS, 10, 0);
    fetch(32'h44, ADD, 0, -1);
    fetch(32'h48, SYS, 10, -1);
    idle(2);

    // Five fetches at the same PC halt on the fifth.
    step(1, 0, 0, 0, 0, -1);
    for (int k = 0; k < 5; k++) fetch(32'h20, ADD, 0, -1);
    idle(1);
    // A broken streak does not halt.
    step(1, 0, 0, 0, 0, -1);
    for (int k = 0; k < 4; k++) fetch(32'h20, ADD, 0, -1);
    fetch(32'h24, ADD, 0, -1);
    fetch(32'h20, ADD, 0, -1);
    // A first fetch at PC 0 is not a repeat of the reset last_pc.
    step(1, 0, 0, 0, 0, -1);
    for (int k = 0; k < 4; k++) fetch(32'h0, ADD, 0, -1);
    idle(1);

    // Timeout with no fetches.
    step(1, 0, 0, 0, 0, -1);
    idle(MC + 2);
    // Exit syscall on the timeout edge: the syscall wins.
    step(1, 0, 0, 0, 0, -1);
    idle(MC - 1);
    fetch(32'h80, SYS, 10, -1);
    idle(1);

    // Ring wrap: 20 fetches, then read ages 0 and 15.
    step(1, 0, 0, 0, 0, -1);
    for (int k = 0; k < 20; k++) fetch(32'h100 + 32'(4 * k), ADD, 0, -1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 15);
    // clear together with a fetch: the fetch is dropped.
    step(1, 1, 32'h200, ADD, 0, -1);
    fetch(32'h204, ADD, 0, -1);
    async_reset_check();

    // Random runs over a small PC set so repeats and loops occur naturally.
    for (int s = 0; s < 40; s++) begin
      step(1, 0, 0, 0, 0, -1);
      n = $urandom_range(20, 60);
      rpc = 32'h20;
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(1) == 0) rpc = 32'h20 + 32'(4 * $urandom_range(0, 3));
        rir = ($urandom_range(9) == 0) ? SYS : $urandom;
        rv0 = ($urandom_range(1) == 0) ? 32'd10 : 32'($urandom_range(0, 20));
        step($urandom_range(49) == 0, $urandom_range(9) < 6, rpc, rir, rv0, -1);
      end
      if ($urandom_range(7) == 0) async_reset_check();
    end

    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
